// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default width and FSM encodings.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           dividend_bit,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted[WIDTH:0] - divisor;
        // Full-width compare so a remainder bit shifted past WIDTH is never lost.
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: magnitudes divided by restoring iteration, signs applied at the end.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Magnitude of a WIDTH-bit value read back as unsigned, so the most negative
    // operand maps to 2^(WIDTH-1) without truncation.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic             dz_pend_q, dz_pend_d;
    logic             ovf_pend_q, ovf_pend_d;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in      (rem_q),
        .dividend_bit(quo_q[WIDTH-1]),
        .divisor     (dvsr_q),
        .rem_out     (step_rem),
        .q_bit       (step_qbit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        q_out_d    = q_out_q;
        r_out_d    = r_out_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        a_d        = a_q;
        sgn_q_d    = sgn_q_q;
        sgn_r_d    = sgn_r_q;
        dz_pend_d  = dz_pend_q;
        ovf_pend_d = ovf_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ITER;
                    cnt_d      = '0;
                    rem_d      = '0;
                    quo_d      = cond_neg(A, A[WIDTH-1]);
                    dvsr_d     = {1'b0, cond_neg(B, B[WIDTH-1])};
                    a_d        = A;
                    sgn_q_d    = A[WIDTH-1] ^ B[WIDTH-1];
                    sgn_r_d    = A[WIDTH-1];
                    dz_pend_d  = (B == '0);
                    ovf_pend_d = (A == MIN_VAL) && (B == '1);
                end
            end
            ST_ITER: begin
                // Dividend bits leave the top of quo_q as quotient bits enter the bottom.
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                dz_d    = dz_pend_q;
                ovf_d   = ovf_pend_q;
                if (dz_pend_q) begin
                    q_out_d = '1;
                    r_out_d = a_q;
                end else if (ovf_pend_q) begin
                    q_out_d = MIN_VAL;
                    r_out_d = '0;
                end else begin
                    q_out_d = cond_neg(quo_q, sgn_q_q);
                    r_out_d = cond_neg(rem_q[WIDTH-1:0], sgn_r_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Working registers are only consumed after a start reloads them.
    always_ff @(posedge clk) begin
        quo_q      <= quo_d;
        rem_q      <= rem_d;
        dvsr_q     <= dvsr_d;
        a_q        <= a_d;
        sgn_q_q    <= sgn_q_d;
        sgn_r_q    <= sgn_r_d;
        dz_pend_q  <= dz_pend_d;
        ovf_pend_q <= ovf_pend_d;
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign Q           = q_out_q;
    assign R           = r_out_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: stimulus pushes model results, a monitor checks each done.
module tb_seq_signed_divider;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        logic [31:0]  done_at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, dz, ovf;
    logic [W-1:0] q_out, r_out;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (a_in),
        .B          (b_in),
        .busy       (busy),
        .done       (done),
        .Q          (q_out),
        .R          (r_out),
        .div_by_zero(dz),
        .overflow   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain signed integer division with the two special cases.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] at);
        int   ai, bi, qi, ri;
        exp_t e;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (bi == 0) begin
            qi = -1; ri = ai; e.dz = 1'b1;
        end else if (ai == -(1 << (W-1)) && bi == -1) begin
            qi = ai; ri = 0; e.ovf = 1'b1;
        end else begin
            qi = ai / bi; ri = ai % bi;
        end
        e.q = qi[W-1:0];
        e.r = ri[W-1:0];
        e.done_at = at;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("Q", 32'(q_out), 32'(e.q));
                chk("R", 32'(r_out), 32'(e.r));
                chk("div_by_zero", 32'(dz), 32'(e.dz));
                chk("overflow", 32'(ovf), 32'(e.ovf));
                chk("done_edge", cyc - 1, e.done_at);
            end
        end
    end

    // Presents an operation for one edge; returns the accepting edge index.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push, output int unsigned n);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        n = cyc;
        if (push) sb.push_back(model(a, b, n + LAT));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Next operation is offered in the done cycle of this one.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned n;
        do_op(a, b, 1'b1, n);
        repeat (LAT - 1) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        int          busy_cnt;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_Q", 32'(q_out), 32'd0);
        chk("reset_R", 32'(r_out), 32'd0);
        chk("reset_dz", 32'(dz), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        do_op(16'd100, 16'd7, 1'b1, n);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(LAT));

        run_op(-16'sd100, 16'sd7);
        run_op(16'sd100, -16'sd7);
        run_op(-16'sd100, -16'sd7);
        run_op(16'h8000, 16'hFFFF);
        run_op(16'd5, 16'd0);
        run_op(16'h8000, 16'd1);
        run_op(16'h7FFF, 16'h8000);

        // start while busy, with different operands, must be ignored
        do_op(16'd1000, 16'd33, 1'b1, n);
        repeat (4) @(negedge clk);
        a_in  = 16'd9;
        b_in  = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 6) @(negedge clk);

        // start held through the done cycle: second op accepted on the edge after done
        do_op(16'd2000, 16'd3, 1'b1, n);
        repeat (LAT - 2) @(negedge clk);
        a_in  = -16'sd1234;
        b_in  = 16'sd10;
        start = 1'b1;
        sb.push_back(model(a_in, b_in, n + LAT + 1 + LAT));
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (LAT + 5) @(negedge clk);

        // reset mid-operation: abort, clear outputs, no done
        do_op(16'd4321, 16'd5, 1'b0, n);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_Q", 32'(q_out), 32'd0);
        chk("midrst_R", 32'(r_out), 32'd0);
        chk("midrst_dz", 32'(dz), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (LAT + 8) @(negedge clk);

        for (int k = 0; k < 3000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 16'h8000; rb = 16'hFFFF; end
                2: rb = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'hFFFF;
                3: ra = 16'h8000;
                4: rb = W'($urandom_range(0, 15)) - 16'd8;
                default: ;
            endcase
            run_op(ra, rb);
        end

        repeat (LAT + 5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
